// File: rtl/uart_packet_parser_if.sv
// Byte-in / command-out handshake bundle between uart_rx, the packet parser and the command/ALU controller.
interface uart_packet_parser_if;
  logic [7:0]  in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [7:0]  cmd_op_o;
  logic [15:0] cmd_len_o;
  logic [7:0]  echo_data_o;
  logic        echo_valid_o;
  logic        echo_last_o;
  logic        echo_ready_i;
  logic [31:0] word_data_o;
  logic        word_valid_o;
  logic        word_last_o;
  logic        word_ready_i;
  logic        err_o;

  modport master (
    output in_data_i, in_valid_i, cmd_ready_i, echo_ready_i, word_ready_i,
    input  in_ready_o, cmd_valid_o, cmd_op_o, cmd_len_o, echo_data_o, echo_valid_o,
           echo_last_o, word_data_o, word_valid_o, word_last_o, err_o
  );

  modport slave (
    input  in_data_i, in_valid_i, cmd_ready_i, echo_ready_i, word_ready_i,
    output in_ready_o, cmd_valid_o, cmd_op_o, cmd_len_o, echo_data_o, echo_valid_o,
           echo_last_o, word_data_o, word_valid_o, word_last_o, err_o
  );
endinterface

// File: rtl/uart_packet_parser.sv
// Frames the uart_rx byte stream into command packets (opcode, reserved, len LSB, len MSB, payload).
// Optional inter-byte idle timeout: define UART_PARSER_TIMEOUT_EN.
module uart_packet_parser #(
  parameter logic [7:0] OP_ECHO = 8'hEC,
  parameter logic [7:0] OP_ADD  = 8'hAD,
  parameter logic [7:0] OP_MUL  = 8'h88,
  parameter logic [7:0] OP_DIV  = 8'hA2
`ifdef UART_PARSER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65536
`endif
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  uart_packet_parser_if.slave bus
);

  localparam logic [2:0] S_OPC   = 3'd0;
  localparam logic [2:0] S_RSV   = 3'd1;
  localparam logic [2:0] S_LSB   = 3'd2;
  localparam logic [2:0] S_MSB   = 3'd3;
  localparam logic [2:0] S_HDR   = 3'd4;
  localparam logic [2:0] S_PAY   = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;

  logic [2:0]  r_state;
  logic [7:0]  r_op;
  logic [7:0]  r_len_lo;
  logic [15:0] r_rem;
  logic        r_is_echo;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;
  logic [7:0]  r_cmd_op;
  logic [15:0] r_cmd_len;
  logic        r_cmd_valid;
  logic [7:0]  r_echo_data;
  logic        r_echo_valid;
  logic        r_echo_last;
  logic [31:0] r_word;
  logic        r_word_valid;
  logic        r_word_last;
  logic        r_err;

  logic        w_in_ready;
  logic        w_in_fire;
  logic        w_cmd_fire;
  logic        w_echo_fire;
  logic        w_word_fire;
  logic        w_timeout;
  logic [15:0] w_len;
  logic [15:0] w_rem;
  logic        w_is_alu;
  logic        w_bad;

  assign w_in_fire   = bus.in_valid_i && w_in_ready;
  assign w_cmd_fire  = r_cmd_valid && bus.cmd_ready_i;
  assign w_echo_fire = r_echo_valid && bus.echo_ready_i;
  assign w_word_fire = r_word_valid && bus.word_ready_i;

  // Header validation uses the MSB byte directly so the verdict lands one cycle after it.
  assign w_len    = {bus.in_data_i, r_len_lo};
  assign w_rem    = w_len - 16'd4;
  assign w_is_alu = (r_op == OP_ADD) || (r_op == OP_MUL) || (r_op == OP_DIV);
  assign w_bad    = (w_len < 16'd4) || !(w_is_alu || (r_op == OP_ECHO)) ||
                    (w_is_alu && ((w_rem < 16'd8) || (w_rem[1:0] != 2'b00)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_OPC, S_RSV, S_LSB, S_MSB, S_DRAIN: w_in_ready = 1'b1;
      S_PAY: w_in_ready = (r_rem != 16'd0) &&
                          (r_is_echo ? (!r_echo_valid || bus.echo_ready_i)
                                     : (!r_word_valid || bus.word_ready_i));
      default: w_in_ready = 1'b0;
    endcase
  end

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);

  logic [IDLE_W-1:0] r_idle;
  logic              w_idle_run;
  logic              w_stall;

  assign w_idle_run = (r_state == S_RSV) || (r_state == S_LSB) || (r_state == S_MSB) ||
                      (r_state == S_PAY) || (r_state == S_DRAIN);
  assign w_stall    = (r_cmd_valid && !bus.cmd_ready_i) || (r_echo_valid && !bus.echo_ready_i) ||
                      (r_word_valid && !bus.word_ready_i);
  assign w_timeout  = w_idle_run && (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idle <= '0;
    end else if (!w_idle_run || w_in_fire || w_stall || w_timeout) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_OPC;
      r_op         <= '0;
      r_len_lo     <= '0;
      r_rem        <= '0;
      r_is_echo    <= 1'b0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_cmd_op     <= '0;
      r_cmd_len    <= '0;
      r_cmd_valid  <= 1'b0;
      r_echo_data  <= '0;
      r_echo_valid <= 1'b0;
      r_echo_last  <= 1'b0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_word_last  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_timeout) begin
        r_err        <= 1'b1;
        r_state      <= S_OPC;
        r_cmd_valid  <= 1'b0;
        r_echo_valid <= 1'b0;
        r_echo_last  <= 1'b0;
        r_word_valid <= 1'b0;
        r_word_last  <= 1'b0;
      end else begin
        case (r_state)
          S_OPC: if (w_in_fire) begin
            r_op    <= bus.in_data_i;
            r_state <= S_RSV;
          end
          S_RSV: if (w_in_fire) r_state <= S_LSB;
          S_LSB: if (w_in_fire) begin
            r_len_lo <= bus.in_data_i;
            r_state  <= S_MSB;
          end
          S_MSB: if (w_in_fire) begin
            r_rem      <= w_rem;
            r_is_echo  <= (r_op == OP_ECHO);
            r_byte_cnt <= '0;
            if (w_bad) begin
              r_err   <= 1'b1;
              r_state <= ((w_len < 16'd4) || (w_rem == 16'd0)) ? S_OPC : S_DRAIN;
            end else begin
              r_cmd_valid <= 1'b1;
              r_cmd_op    <= r_op;
              r_cmd_len   <= w_len;
              r_state     <= S_HDR;
            end
          end
          S_HDR: if (w_cmd_fire) begin
            r_cmd_valid <= 1'b0;
            r_state     <= (r_rem == 16'd0) ? S_OPC : S_PAY;
          end
          S_PAY: begin
            // A byte accepted in the same cycle as an output handshake reloads the channel; later writes win.
            if (r_is_echo) begin
              if (w_echo_fire) begin
                r_echo_valid <= 1'b0;
                r_echo_last  <= 1'b0;
                if (r_echo_last) r_state <= S_OPC;
              end
              if (w_in_fire) begin
                r_echo_data  <= bus.in_data_i;
                r_echo_valid <= 1'b1;
                r_echo_last  <= (r_rem == 16'd1);
                r_rem        <= r_rem - 16'd1;
              end
            end else begin
              if (w_word_fire) begin
                r_word_valid <= 1'b0;
                r_word_last  <= 1'b0;
                if (r_word_last) r_state <= S_OPC;
              end
              if (w_in_fire) begin
                r_rem      <= r_rem - 16'd1;
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_byte_cnt == 2'd3) begin
                  r_word       <= {bus.in_data_i, r_shift};
                  r_word_valid <= 1'b1;
                  r_word_last  <= (r_rem == 16'd1);
                end else begin
                  r_shift <= {bus.in_data_i, r_shift[23:8]};
                end
              end
            end
          end
          S_DRAIN: if (w_in_fire) begin
            r_rem <= r_rem - 16'd1;
            if (r_rem == 16'd1) r_state <= S_OPC;
          end
          default: r_state <= S_OPC;
        endcase
      end
    end
  end

  assign bus.in_ready_o   = w_in_ready;
  assign bus.cmd_valid_o  = r_cmd_valid;
  assign bus.cmd_op_o     = r_cmd_op;
  assign bus.cmd_len_o    = r_cmd_len;
  assign bus.echo_data_o  = r_echo_data;
  assign bus.echo_valid_o = r_echo_valid;
  assign bus.echo_last_o  = r_echo_last;
  assign bus.word_data_o  = r_word;
  assign bus.word_valid_o = r_word_valid;
  assign bus.word_last_o  = r_word_last;
  assign bus.err_o        = r_err;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Self-checking bench for uart_packet_parser: directed packets plus random packets scored against a packet-level model.
module tb_uart_packet_parser;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  uart_packet_parser_if bus ();

`ifdef UART_PARSER_TIMEOUT_EN
  uart_packet_parser #(.TIMEOUT_CYCLES(100)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
`else
  uart_packet_parser dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]  pkt[$];
  logic [7:0]  tx_q[$];
  logic [23:0] exp_cmd[$],  obs_cmd[$];
  logic [8:0]  exp_echo[$], obs_echo[$];
  logic [32:0] exp_word[$], obs_word[$];
  int exp_err = 0, obs_err = 0, stall_viol = 0;
  bit rnd_ready = 1'b0, echo_hold = 1'b0, word_hold = 1'b0;
  logic [7:0] alu_ops[3] = '{8'hAD, 8'h88, 8'hA2};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int n, input logic [127:0] v);
    for (int i = n - 1; i >= 0; i--) pkt.push_back(v[8*i +: 8]);
  endtask

  // Packet-level reference: classify the header, then derive cmd/echo/word/err expectations.
  task automatic add_packet();
    logic [7:0]  op;
    logic [31:0] w;
    int len, rem, nw;
    bit alu, is_bad;
    op     = pkt[0];
    len    = int'(pkt[2]) + 256 * int'(pkt[3]);
    rem    = len - 4;
    alu    = (op == 8'hAD) || (op == 8'h88) || (op == 8'hA2);
    is_bad = (len < 4) || !(alu || op == 8'hEC) || (alu && (rem < 8 || rem % 4 != 0));
    if (is_bad) exp_err++;
    else begin
      exp_cmd.push_back({op, 16'(len)});
      if (!alu) begin
        for (int i = 0; i < rem; i++) exp_echo.push_back({(i == rem - 1), pkt[4+i]});
      end else begin
        nw = rem / 4;
        for (int j = 0; j < nw; j++) begin
          w = 0;
          for (int k = 0; k < 4; k++) w = w | (32'(pkt[4+4*j+k]) << (8 * k));
          exp_word.push_back({(j == nw - 1), w});
        end
      end
    end
    foreach (pkt[i]) tx_q.push_back(pkt[i]);
    pkt.delete();
  endtask

  task automatic gen_random();
    int kind, len;
    logic [7:0] op;
    kind = $urandom_range(0, 4);
    case (kind)
      0: begin op = 8'hEC; len = $urandom_range(4, 24); end
      1: begin op = alu_ops[$urandom_range(0, 2)]; len = 4 + 4 * $urandom_range(2, 5); end
      2: begin
        do op = 8'($urandom); while (op == 8'hEC || op == 8'hAD || op == 8'h88 || op == 8'hA2);
        len = $urandom_range(4, 10);
      end
      3: begin
        op = alu_ops[$urandom_range(0, 2)];
        do len = 4 + $urandom_range(0, 13); while (len - 4 >= 8 && (len - 4) % 4 == 0);
      end
      default: begin op = 8'($urandom); len = $urandom_range(0, 3); end
    endcase
    pkt.push_back(op);
    pkt.push_back(8'($urandom));
    pkt.push_back(8'(len));
    pkt.push_back(8'(len >> 8));
    for (int i = 0; i < len - 4; i++) pkt.push_back(8'($urandom));
    add_packet();
  endtask

  task automatic send_all(input bit gaps);
    int stuck = 0;
    bit timed_out = 1'b0;
    while (tx_q.size() > 0 && !timed_out) begin
      @(negedge clk_i);
      if (gaps && $urandom_range(0, 2) == 0) bus.in_valid_i = 1'b0;
      else begin
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = tx_q[0];
      end
      #1;
      if (bus.in_valid_i && bus.in_ready_o) begin
        void'(tx_q.pop_front());
        stuck = 0;
      end else if (++stuck > 3000) timed_out = 1'b1;
    end
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    check("input accepted in time", 64'(timed_out), 64'(0));
    tx_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int idle = 0, n = 0;
    while (idle < 6 && n < 4000) begin
      @(negedge clk_i);
      #2;
      if (!bus.cmd_valid_o && !bus.echo_valid_o && !bus.word_valid_o) idle++;
      else idle = 0;
      n++;
    end
    check({tag, " outputs drained"}, 64'(idle >= 6), 64'(1));
    check({tag, " in_ready idle"}, 64'(bus.in_ready_o), 64'(1));
  endtask

  task automatic compare_all(input string tag);
    check({tag, " cmd count"}, 64'(obs_cmd.size()), 64'(exp_cmd.size()));
    for (int i = 0; i < exp_cmd.size() && i < obs_cmd.size(); i++)
      check($sformatf("%s cmd[%0d]", tag, i), 64'(obs_cmd[i]), 64'(exp_cmd[i]));
    check({tag, " echo count"}, 64'(obs_echo.size()), 64'(exp_echo.size()));
    for (int i = 0; i < exp_echo.size() && i < obs_echo.size(); i++)
      check($sformatf("%s echo[%0d]", tag, i), 64'(obs_echo[i]), 64'(exp_echo[i]));
    check({tag, " word count"}, 64'(obs_word.size()), 64'(exp_word.size()));
    for (int i = 0; i < exp_word.size() && i < obs_word.size(); i++)
      check($sformatf("%s word[%0d]", tag, i), 64'(obs_word[i]), 64'(exp_word[i]));
    check({tag, " err pulses"}, 64'(obs_err), 64'(exp_err));
    check({tag, " held while stalled"}, 64'(stall_viol), 64'(0));
    exp_cmd.delete(); obs_cmd.delete(); exp_echo.delete(); obs_echo.delete();
    exp_word.delete(); obs_word.delete();
    exp_err = 0; obs_err = 0; stall_viol = 0;
  endtask

  task automatic monitor();
    bit st_cmd = 1'b0, st_echo = 1'b0, st_word = 1'b0;
    logic [23:0] h_cmd;
    logic [8:0]  h_echo;
    logic [32:0] h_word;
    forever begin
      @(negedge clk_i);
      bus.cmd_ready_i  = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.echo_ready_i = echo_hold ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.word_ready_i = word_hold ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      #1;
      if (st_cmd && bus.cmd_valid_o && {bus.cmd_op_o, bus.cmd_len_o} !== h_cmd) stall_viol++;
      if (st_echo && bus.echo_valid_o && {bus.echo_last_o, bus.echo_data_o} !== h_echo) stall_viol++;
      if (st_word && bus.word_valid_o && {bus.word_last_o, bus.word_data_o} !== h_word) stall_viol++;
      st_cmd  = bus.cmd_valid_o && !bus.cmd_ready_i;
      st_echo = bus.echo_valid_o && !bus.echo_ready_i;
      st_word = bus.word_valid_o && !bus.word_ready_i;
      h_cmd   = {bus.cmd_op_o, bus.cmd_len_o};
      h_echo  = {bus.echo_last_o, bus.echo_data_o};
      h_word  = {bus.word_last_o, bus.word_data_o};
      if (bus.cmd_valid_o && bus.cmd_ready_i) obs_cmd.push_back(h_cmd);
      if (bus.echo_valid_o && bus.echo_ready_i) obs_echo.push_back(h_echo);
      if (bus.word_valid_o && bus.word_ready_i) obs_word.push_back(h_word);
      if (bus.err_o) obs_err++;
    end
  endtask

  initial begin
    int n;
    bus.in_valid_i   = 1'b0;
    bus.in_data_i    = 8'h00;
    bus.cmd_ready_i  = 1'b1;
    bus.echo_ready_i = 1'b1;
    bus.word_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset in_ready", 64'(bus.in_ready_o), 64'(1));
    check("reset valids", 64'({bus.cmd_valid_o, bus.echo_valid_o, bus.word_valid_o}), 64'(0));
    check("reset err", 64'(bus.err_o), 64'(0));
    check("reset data", 64'({bus.cmd_op_o, bus.cmd_len_o, bus.echo_data_o, bus.word_data_o}), 64'(0));
    rst_ni = 1'b1;
    fork monitor(); join_none

    // Echo packet with readies held high.
    put(7, 128'hEC_00_07_00_11_22_33); add_packet();
    send_all(1'b0); wait_idle("echo");
    check("echo last byte 33", 64'(obs_echo.size() == 3 ? obs_echo[2] : 9'h0), 64'({1'b1, 8'h33}));
    compare_all("echo");

    // Add packet followed by a normal echo packet.
    put(12, 128'hAD_00_0C_00_01_00_00_00_02_00_00_00); add_packet();
    put(5, 128'hEC_00_05_00_5A); add_packet();
    send_all(1'b0); wait_idle("add");
    compare_all("add");

    // Operand backpressure for 50 cycles.
    word_hold = 1'b1;
    put(12, 128'hAD_00_0C_00_01_00_00_00_02_00_00_00); add_packet();
    fork
      send_all(1'b0);
      begin
        n = 0;
        while (!bus.word_valid_o && n < 200) begin @(negedge clk_i); #1; n++; end
        repeat (50) @(negedge clk_i);
        #1;
        check("bp word held", 64'(bus.word_data_o), 64'h1);
        check("bp in_ready low", 64'(bus.in_ready_o), 64'(0));
        word_hold = 1'b0;
      end
    join
    wait_idle("backpressure");
    compare_all("backpressure");

    // Unknown opcode drained, then a zero-payload echo.
    put(6, 128'h5B_00_06_00_AA_BB); add_packet();
    put(4, 128'hEC_00_04_00); add_packet();
    send_all(1'b0); wait_idle("malformed");
    compare_all("malformed");

    // ALU length error, then length below header size.
    put(9, 128'h88_00_09_00_01_02_03_04_05); add_packet();
    put(4, 128'hEC_00_02_00); add_packet();
    put(5, 128'hEC_00_05_00_77); add_packet();
    send_all(1'b0); wait_idle("len errors");
    compare_all("len errors");

    // 256-byte echo payload crosses the length-MSB boundary.
    put(4, 128'hEC_00_04_01);
    for (int i = 0; i < 256; i++) pkt.push_back(8'($urandom));
    add_packet();
    send_all(1'b1); wait_idle("long echo");
    compare_all("long echo");

    // Reset while an echo byte is pending.
    echo_hold = 1'b1;
    put(5, 128'hEC_00_0A_00_42);
    foreach (pkt[i]) tx_q.push_back(pkt[i]);
    pkt.delete();
    send_all(1'b0);
    repeat (3) @(negedge clk_i);
    #1;
    check("pre-reset echo pending", 64'(bus.echo_valid_o), 64'(1));
    rst_ni = 1'b0;
    #1;
    check("mid reset valids", 64'({bus.cmd_valid_o, bus.echo_valid_o, bus.word_valid_o, bus.err_o}), 64'(0));
    obs_cmd.delete();
    @(negedge clk_i);
    rst_ni    = 1'b1;
    echo_hold = 1'b0;
    put(6, 128'hEC_00_06_00_C3_3C); add_packet();
    send_all(1'b0); wait_idle("after reset");
    compare_all("after reset");

`ifdef UART_PARSER_TIMEOUT_EN
    // Stall after the length LSB; the idle counter must abort the packet.
    put(3, 128'hEC_00_07);
    foreach (pkt[i]) tx_q.push_back(pkt[i]);
    pkt.delete();
    send_all(1'b0);
    exp_err = 1;
    n = 0;
    while (obs_err == 0 && n < 300) begin @(negedge clk_i); #2; n++; end
    check("timeout back in OPC", 64'(bus.in_ready_o), 64'(1));
    put(5, 128'hEC_00_05_00_99); add_packet();
    send_all(1'b0); wait_idle("timeout");
    compare_all("timeout");
`endif

    // Random packet mix with input gaps and random readies.
    rnd_ready = 1'b1;
    for (int p = 0; p < 30; p++) gen_random();
    send_all(1'b1); wait_idle("random");
    compare_all("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
